// File: rtl/apb_bridge_ctrl.sv
// rtl/apb_bridge_ctrl.sv - AHB-to-APB bridge controller with APB wait states, slave errors and optional access timeout
//
// Optional feature macro: APB_TIMEOUT_EN (abort an ACCESS phase after TIMEOUT_CYC cycles without pready)
//
// Ports:
//   hclk, hresetn          clock, asynchronous active-low reset
//   valid                  qualified AHB transfer request from the slave-interface front end
//   hwrite, haddr          direction and address of the request (address phase)
//   hwdata                 write data, valid in the cycle after the address is accepted
//   tempselx               decoded one-hot APB slave select, valid with haddr
//   prdata, pready, pslverr APB read data, ready and slave error
//   hreadyout, hresp       AHB ready and ERROR response
//   hrdata                 AHB read data
//   paddr, pwdata, pwrite  registered APB address, write data and direction
//   penable, pselx         registered APB enable and one-hot select
module apb_bridge_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               valid,
    input  logic               hwrite,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [DATA_W-1:0]  hwdata,
    input  logic [NUM_SLV-1:0] tempselx,
    input  logic [DATA_W-1:0]  prdata,
    input  logic               pready,
    input  logic               pslverr,
    output logic               hreadyout,
    output logic               hresp,
    output logic [DATA_W-1:0]  hrdata,
    output logic [ADDR_W-1:0]  paddr,
    output logic [DATA_W-1:0]  pwdata,
    output logic               pwrite,
    output logic               penable,
    output logic [NUM_SLV-1:0] pselx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WWAIT,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              state;
    state_t              next_state;
    state_t              accept_dest;

    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [NUM_SLV-1:0]  sel_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                sel_ok;
    logic                accept;
    logic                done_ok;
    logic                timeout_hit;

    // A select is usable only if exactly one bit is set: nonzero and no second bit.
    assign sel_ok = (tempselx != '0) && ((tempselx & (tempselx - NUM_SLV'(1))) == '0);

    assign done_ok   = (state == S_ACCESS) && pready && !pslverr;
    assign hreadyout = (state == S_IDLE) || (state == S_ERR2) || done_ok;
    assign hresp     = (state == S_ERR1) || (state == S_ERR2);
    assign accept    = valid && hreadyout;

    // During a read ACCESS the AHB side sees the APB bus directly; elsewhere
    // it sees the last successfully completed read.
    assign hrdata = ((state == S_ACCESS) && !pwrite) ? prdata : rdata_q;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] to_cnt;

    // Held at zero outside ACCESS, so every ACCESS phase starts counting from zero.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            to_cnt <= '0;
        end else if (state != S_ACCESS) begin
            to_cnt <= '0;
        end else if (!pready) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // pready in the final cycle still completes normally; only a missing pready aborts.
    assign timeout_hit = (state == S_ACCESS) && !pready &&
                         (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    // No counter: ACCESS waits for pready indefinitely. TIMEOUT_CYC stays
    // referenced so both builds share the same parameter list.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYC > 0);
`endif

    // Where an accepted request goes: bad selects never reach the APB bus.
    always_comb begin
        accept_dest = S_SETUP;
        if (!sel_ok) begin
            accept_dest = S_ERR1;
        end else if (hwrite) begin
            accept_dest = S_WWAIT;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_ERR2: begin
                next_state = accept ? accept_dest : S_IDLE;
            end
            S_WWAIT: begin
                next_state = S_SETUP;
            end
            S_SETUP: begin
                next_state = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        next_state = S_ERR1;
                    end else begin
                        next_state = accept ? accept_dest : S_IDLE;
                    end
                end else if (timeout_hit) begin
                    next_state = S_ERR1;
                end
            end
            S_ERR1: begin
                next_state = S_ERR2;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Request latch, write-data capture and read-data hold.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            pwdata  <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= haddr;
                write_q <= hwrite;
                sel_q   <= tempselx;
            end
            if (state == S_WWAIT) begin
                pwdata <= hwdata;
            end
            if (done_ok && !pwrite) begin
                rdata_q <= prdata;
            end
        end
    end

    // APB control outputs take the value of the state being entered.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            paddr   <= '0;
            pwrite  <= 1'b0;
            pselx   <= '0;
            penable <= 1'b0;
        end else begin
            case (next_state)
                S_SETUP: begin
                    // Writes come through WWAIT and use the latched request;
                    // reads enter SETUP on the accept edge itself, so the
                    // live address-phase signals are the request.
                    if (state == S_WWAIT) begin
                        paddr  <= addr_q;
                        pwrite <= write_q;
                        pselx  <= sel_q;
                    end else begin
                        paddr  <= haddr;
                        pwrite <= hwrite;
                        pselx  <= tempselx;
                    end
                    penable <= 1'b0;
                end
                S_ACCESS: begin
                    penable <= 1'b1;
                end
                default: begin
                    pselx   <= '0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// tb/tb_apb_bridge_ctrl.sv - randomized self-checking bench for apb_bridge_ctrl
module tb_apb_bridge_ctrl;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NS      = 4;
    localparam int TO_CYC  = 16;
    localparam int N_XFER  = 250;
    localparam int MAX_CYC = 20000;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [NS-1:0] sel;
        int            waits;
        logic          err;
    } req_t;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          valid;
    logic          hwrite;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
    logic [NS-1:0] tempselx;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic          hreadyout;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          penable;
    logic [NS-1:0] pselx;

    int n_cmp = 0;
    int n_err = 0;

    apb_bridge_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
        .haddr(haddr), .hwdata(hwdata), .tempselx(tempselx),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .penable(penable), .pselx(pselx)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(req_t r);
        return $countones(r.sel) != 1;
    endfunction

    function automatic bit timed_out(req_t r);
        return TO_EN && !is_bad(r) && (r.waits >= TO_CYC);
    endfunction

    function automatic bit is_err(req_t r);
        return is_bad(r) || timed_out(r) || r.err;
    endfunction

    // Cycles from the accept edge up to and including the cycle hreadyout returns high.
    function automatic int exp_cycles(req_t r);
        if (is_bad(r)) return 2;
        return (r.wr ? 3 : 2) + (timed_out(r) ? TO_CYC - 1 : r.waits) + (is_err(r) ? 2 : 0);
    endfunction

    function automatic req_t mk_req(logic wr, logic [AW-1:0] a, logic [DW-1:0] wd,
                                    logic [DW-1:0] rd, logic [NS-1:0] s, int w, logic e);
        req_t r;
        r.wr = wr; r.addr = a; r.wdata = wd; r.rdata = rd; r.sel = s; r.waits = w; r.err = e;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.wr    = 1'($urandom_range(0, 1));
        r.addr  = $urandom & 32'hFFFF_FFFC;
        r.wdata = $urandom;
        r.rdata = $urandom;
        if ($urandom_range(0, 9) == 0) r.sel = 4'($urandom);
        else                           r.sel = 4'b0001 << $urandom_range(0, 3);
        r.waits = ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(1, 4);
        if (TO_EN && $urandom_range(0, 19) == 0) r.waits = $urandom_range(TO_CYC - 1, TO_CYC + 4);
        r.err   = ($urandom_range(0, 7) == 0);
        return r;
    endfunction

    req_t q[$];
    req_t pend;
    req_t cur;
    bit   inflight = 0;
    bit   took = 0;
    bit   stuck = 0;
    bit   prev_hresp = 0;
    int   wcnt = 0;
    int   acc_cnt = 0;
    int   n_pres = 0;
    int   n_done = 0;
    int   cyc = 0;
    logic [DW-1:0] last_rd = '0;

    initial begin
        hresetn = 1'b0; valid = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
        tempselx = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(negedge hclk);
        check("reset_apb", {paddr, pwrite, penable, pselx}, 64'd0);
        check("reset_pwdata", pwdata, 64'd0);
        check("reset_ahb", {hreadyout, hresp, hrdata}, {1'b1, 1'b0, 32'd0});
        hresetn = 1'b1;

        q.push_back(mk_req(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 4'b0010, 0, 1'b0));
        q.push_back(mk_req(1'b1, 32'h10, 32'h1234, 32'h0, 4'b0001, 3, 1'b0));
        q.push_back(mk_req(1'b1, 32'h20, 32'hA5A5_0001, 32'h0, 4'b0100, 0, 1'b0));
        q.push_back(mk_req(1'b0, 32'h24, 32'h0, 32'h1357_9BDF, 4'b1000, 0, 1'b0));
        q.push_back(mk_req(1'b0, 32'h30, 32'h0, 32'h0BAD_0BAD, 4'b0010, 0, 1'b1));
        q.push_back(mk_req(1'b0, 32'h34, 32'h0, 32'h0, 4'b0000, 0, 1'b0));
        q.push_back(mk_req(1'b1, 32'h38, 32'h77, 32'h0, 4'b0110, 0, 1'b0));
        if (TO_EN) q.push_back(mk_req(1'b0, 32'h3C, 32'h0, 32'h55, 4'b0001, 100, 1'b0));

        while (n_done < N_XFER && cyc < MAX_CYC && !stuck) begin
            @(negedge hclk);
            cyc++;

            // AHB master: once a request has been taken, present the next one (or idle junk)
            if (took) begin valid = 1'b0; took = 0; end
            if (!valid && n_pres < N_XFER && (q.size() > 0 || $urandom_range(0, 9) < 7)) begin
                pend     = (q.size() > 0) ? q.pop_front() : rand_req();
                valid    = 1'b1;
                hwrite   = pend.wr;
                haddr    = pend.addr;
                tempselx = pend.sel;
                n_pres++;
            end else if (!valid) begin
                hwrite = 1'($urandom); haddr = $urandom; tempselx = 4'($urandom);
            end

            // APB slave model and bus-level checks
            if (penable) begin
                check("apb_access", {paddr, pwrite, pselx}, {cur.addr, cur.wr, cur.sel});
                if (cur.wr) check("apb_pwdata", pwdata, cur.wdata);
                pready  = (acc_cnt == cur.waits);
                pslverr = pready && cur.err;
                prdata  = cur.wr ? $urandom : cur.rdata;
                acc_cnt++;
            end else begin
                pready  = 1'($urandom);
                pslverr = 1'($urandom);
                prdata  = $urandom;
                check("hrdata_hold", hrdata, last_rd);
                if (!inflight || is_bad(cur) || hresp)
                    check("psel_off", pselx, 64'd0);
                else if (pselx != '0)
                    check("apb_setup", {paddr, pwrite, pselx}, {cur.addr, cur.wr, cur.sel});
            end

            #1;
            if (!inflight) check("idle_ready", hreadyout, 64'd1);
            if (inflight) begin
                wcnt++;
                if (hreadyout) begin
                    check("xfer_cycles", wcnt, exp_cycles(cur));
                    check("hresp_pair", {prev_hresp, hresp}, is_err(cur) ? 2'b11 : 2'b00);
                    if (!cur.wr && !is_err(cur)) begin
                        check("read_data", hrdata, cur.rdata);
                        last_rd = cur.rdata;
                    end
                    inflight = 0;
                    n_done++;
                end else if (wcnt > 64) begin
                    check("xfer_stall", wcnt, exp_cycles(cur));
                    stuck = 1;
                end
            end
            prev_hresp = hresp;

            if (hreadyout && valid) begin
                cur      = pend;
                inflight = 1;
                wcnt     = 0;
                acc_cnt  = 0;
                took     = 1;
                hwdata   = pend.wdata;
            end
        end
        if (n_done < N_XFER) check("xfers_done", n_done, N_XFER);

        // Reset asserted in the middle of an ACCESS phase
        @(negedge hclk);
        hwrite = 1'b0; haddr = 32'h80; tempselx = 4'b0100; valid = 1'b1;
        pready = 1'b0; pslverr = 1'b0;
        @(negedge hclk);
        valid = 1'b0;
        @(negedge hclk);
        check("rst_pre_access", {penable, pselx}, 5'b1_0100);
        #2 hresetn = 1'b0;
        #1;
        check("rst_apb", {paddr, pwrite, penable, pselx}, 64'd0);
        check("rst_pwdata", pwdata, 64'd0);
        check("rst_ahb", {hreadyout, hresp, hrdata}, {1'b1, 1'b0, 32'd0});
        @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
